gray_decoder_checker: RTL

//  Receive end of the gray-counter link. Samples a WIDTH-bit gray word every clk,

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray2bin_comb.sv | 14 +
 rtl/gray_decoder_checker.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the gray-counter link: FSM state encodings and a
// reference gray-to-binary helper reused by the counter-side bench.
package gray_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Decodes the low 'width' bits of g; bits at or above 'width' return 0.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
        logic [31:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < width) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational gray-to-binary decoder: each binary bit is the XOR of
// all gray bits at or above its position.
module gray2bin_comb #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_decoder_checker.sv
// Receive side of the gray-counter link: decodes each sampled word and checks
// that it advances by exactly one per enabled cycle, tracking lock and errors.
//
// state     | meaning
// ST_IDLE   | link disabled, outputs cleared, no checking
// ST_ACQ    | counting consecutive good increments toward lock
// ST_LOCKED | tracking; any break pulses err and drops back to ST_ACQ
module gray_decoder_checker
    import gray_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             valid,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [GW-1:0]    good_q, good_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;
    logic [WIDTH-1:0] dec;
    logic             match;

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
        .gray_i (gray_in),
        .bin_o  (dec)
    );

    // A repeated value (dec == ref) fails this test as well as any jump.
    assign match = (dec == (ref_q + WIDTH'(1)));

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        good_d   = good_q;
        bin_d    = bin_q;
        valid_d  = valid_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;

        if (!enable) begin
            state_d  = ST_IDLE;
            bin_d    = '0;
            valid_d  = 1'b0;
            locked_d = 1'b0;
            good_d   = '0;
        end else begin
            bin_d   = dec;
            valid_d = 1'b1;
            ref_d   = dec;
            case (state_q)
                ST_ACQ: begin
                    if (!match) begin
                        good_d = '0;
                    end else if (good_q == LOCK_LAST) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        state_d  = ST_ACQ;
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        if (errcnt_q != '1) begin
                            errcnt_d = errcnt_q + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_ACQ;
                    good_d   = '0;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (err_clr) begin
            errcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ref_q    <= '0;
            good_q   <= '0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            good_q   <= good_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign bin_out   = bin_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = errcnt_q;

endmodule
